accel_spi_reader: RTL and testbench
===================================

ACCEL_SPI_READER -- requirements
Module: accel_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, meaning iCLK cycles per SCLK half-period; legal values 2..255.
REQ-002 SHALL have parameter CS_GAP, default 32, meaning the minimum iCLK cycles oSPI_CSN stays high between transactions.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock.
REQ-004 SHALL have port iRSTN, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port iG_INT1, input, 1 bit: sensor data-ready, active high, asynchronous to iCLK.
REQ-006 SHALL have port iSPI_SDI, input, 1 bit: MISO from the sensor.
REQ-007 SHALL have port oSPI_CSN, output, 1 bit: chip select, active low.
REQ-008 SHALL have port oSPI_CLK, output, 1 bit: SCLK, SPI mode 3 (idles high).
REQ-009 SHALL have port oSPI_SDO, output, 1 bit: MOSI.
REQ-010 SHALL have port oDIG, output, 10 bits: latest X-axis sample, two's complement.
REQ-011 SHALL have port oDATA_INT, output, 1 bit: high while a read is in flight; its falling edge marks a new oDIG.

Function
REQ-012 SHALL pass iG_INT1 through a 2-flop synchronizer before any use.
REQ-013 SHALL use states INIT, INIT_GAP, IDLE, READ, READ_GAP.
- INIT: one write per entry.
- INIT_GAP: CS_GAP wait after each write.
- READ: one 24-bit read.
- READ_GAP: CS_GAP wait after the read.
REQ-014 SHALL, after reset, issue four 16-bit writes in this order, each as {R/W=0, MB=0, addr[5:0], data[7:0]}:
- 0x31 <= 0x00
- 0x2C <= 0x0A
- 0x2E <= 0x80
- 0x2D <= 0x08
REQ-015 SHALL enter IDLE after the fourth write's INIT_GAP completes.
REQ-016 SHALL ignore iG_INT1 in INIT and INIT_GAP.
REQ-017 SHALL start a READ from IDLE on any cycle where the synchronized iG_INT1 is 1 (level-sensitive).
REQ-018 SHALL make each read 24 bits.
- Command byte 0xF2 (R/W=1, MB=1, addr 0x32).
- Then two data bytes, DATAX0 first, then DATAX1.
- oSPI_SDO = 0 during both data bytes.
REQ-019 SHALL time a B-bit transaction as follows, relative to cycle 0:
- Cycle 0: oSPI_CSN falls and oSPI_SDO presents the first bit (MSB first within each byte).
- Each bit: oSPI_CLK falls CLK_DIV cycles after the previous edge; oSPI_SDO changes only on that falling edge (first bit excepted); oSPI_CLK rises CLK_DIV cycles later.
- On each oSPI_CLK rising edge: iSPI_SDI is sampled into the shift register.
- After the last rise: oSPI_CSN rises CLK_DIV cycles later.
- Total oSPI_CSN low time: CLK_DIV*(2B+1) cycles.
REQ-020 SHALL form oDIG = {DATAX1[1:0], DATAX0[7:0]} and discard DATAX1[7:2].
REQ-021 SHALL update oDIG on the cycle oSPI_CSN rises at the end of a READ, and hold it otherwise.
REQ-022 SHALL drive oDATA_INT as follows:
- Set to 1 on the cycle oSPI_CSN falls for a READ.
- Clear to 0 on the same cycle oDIG updates.
- Never assert it for INIT writes.
REQ-023 SHALL keep oSPI_CLK = 1 and oSPI_SDO = 0 whenever oSPI_CSN = 1.
REQ-024 SHALL return from READ_GAP to IDLE after CS_GAP cycles, and re-evaluate iG_INT1 only in IDLE, so an interrupt still high re-triggers immediately.
REQ-025 SHALL neither queue nor abort on iG_INT1 changes during READ or READ_GAP.

Reset
REQ-026 SHALL, while iRSTN = 0, asynchronously force:
- oSPI_CSN = 1, oSPI_CLK = 1, oSPI_SDO = 0
- oDIG = 0, oDATA_INT = 0
- state = INIT with write index 0
- synchronizer flops = 0, all counters = 0
REQ-027 SHALL, on reset mid-transaction, abort immediately with oSPI_CSN high, no partial oDIG update, and restart the full init sequence on release.

Verification
REQ-028 SHALL cover post-reset init:
- Stimulus: release reset with CLK_DIV = 8, iG_INT1 = 1.
- Response: exactly four CSN-low windows of 264 cycles each.
- MOSI words 0x3100, 0x2C0A, 0x2E80, 0x2D08.
- Gaps of at least 32 cycles between windows.
- No oDATA_INT activity.
REQ-029 SHALL cover a single read:
- Stimulus: in IDLE, pulse iG_INT1; sensor model returns DATAX0 = 0x34, DATAX1 = 0xFE.
- Response: command 0xF2, CSN low for 392 cycles.
- oDIG = 0x234 and oDATA_INT falls in the same cycle CSN rises.
REQ-030 SHALL cover negative full scale:
- Stimulus: DATAX0 = 0x00, DATAX1 = 0x02.
- Response: oDIG = 0x200.
REQ-031 SHALL cover back-to-back interrupts:
- Stimulus: hold iG_INT1 = 1 continuously.
- Response: consecutive reads with CSN-high gaps of exactly CS_GAP + 3 ± 1 cycles.
- oDATA_INT shows one falling edge per read.
REQ-032 SHALL cover reset mid-read:
- Stimulus: assert iRSTN low at bit 10 of a READ.
- Response: CSN = 1 and oDATA_INT = 0 in the same cycle, oDIG = 0.
- Init sequence replays from write 0x3100 after release.
REQ-033 SHALL cover the minimum divider:
- Stimulus: CLK_DIV = 2, one read.
- Response: SCLK period of 4 cycles, CSN low for 98 cycles, correct oDIG.

Source files
------------

// File: rtl/accel_spi_reader.sv
// Accelerometer SPI reader: writes the sensor setup registers after reset, then reads the
// 10-bit X-axis sample over mode-3 SPI whenever the data-ready interrupt is high in IDLE.
module accel_spi_reader #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned CS_GAP  = 32
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iG_INT1,
    input  logic       iSPI_SDI,
    output logic       oSPI_CSN,
    output logic       oSPI_CLK,
    output logic       oSPI_SDO,
    output logic [9:0] oDIG,
    output logic       oDATA_INT
);
    localparam int unsigned GW = $clog2(CS_GAP + 2);

    typedef enum logic [2:0] {
        StInit,
        StInitGap,
        StIdle,
        StRead,
        StReadGap
    } state_e;

    state_e        r_state;
    logic [1:0]    r_idx;
    logic          r_int_meta;
    logic          r_int_sync;
    logic [7:0]    r_div;
    logic [5:0]    r_edge;
    logic [GW-1:0] r_gap;
    logic [23:0]   r_tx;
    logic [15:0]   r_rx;
    logic          r_csn;
    logic          r_sclk;
    logic          r_sdo;
    logic          r_dint;
    logic [9:0]    r_dig;

    logic [15:0] w_word;
    logic [5:0]  w_last_edge;
    logic        w_tick;
    logic        w_is_read;

    always_comb begin
        w_word = 16'h3100;
        case (r_idx)
            2'd0: w_word = 16'h3100;
            2'd1: w_word = 16'h2C0A;
            2'd2: w_word = 16'h2E80;
            2'd3: w_word = 16'h2D08;
        endcase
    end

    assign w_is_read   = (r_state == StRead);
    // Edge 2B (even) is the chip-select release, CLK_DIV cycles after the last rise.
    assign w_last_edge = w_is_read ? 6'd48 : 6'd32;
    assign w_tick      = (r_div == 8'(CLK_DIV - 1));

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            r_state    <= StInit;
            r_idx      <= 2'd0;
            r_int_meta <= 1'b0;
            r_int_sync <= 1'b0;
            r_div      <= 8'd0;
            r_edge     <= 6'd0;
            r_gap      <= '0;
            r_tx       <= 24'd0;
            r_rx       <= 16'd0;
            r_csn      <= 1'b1;
            r_sclk     <= 1'b1;
            r_sdo      <= 1'b0;
            r_dint     <= 1'b0;
            r_dig      <= 10'd0;
        end else begin
            r_int_meta <= iG_INT1;
            r_int_sync <= r_int_meta;
            case (r_state)
                StInit, StRead: begin
                    if (r_csn) begin
                        // Entry cycle: drop chip select and present the first bit.
                        r_csn  <= 1'b0;
                        r_div  <= 8'd0;
                        r_edge <= 6'd0;
                        if (w_is_read) begin
                            r_sdo  <= 1'b1;
                            r_tx   <= {7'h72, 17'h0};
                            r_dint <= 1'b1;
                        end else begin
                            r_sdo <= w_word[15];
                            r_tx  <= {w_word[14:0], 9'h0};
                        end
                    end else if (w_tick) begin
                        r_div  <= 8'd0;
                        r_edge <= r_edge + 6'd1;
                        if (r_edge == w_last_edge) begin
                            r_csn  <= 1'b1;
                            r_sclk <= 1'b1;
                            r_sdo  <= 1'b0;
                            r_gap  <= '0;
                            if (w_is_read) begin
                                r_dig   <= {r_rx[1:0], r_rx[15:8]};
                                r_dint  <= 1'b0;
                                r_state <= StReadGap;
                            end else begin
                                r_state <= StInitGap;
                            end
                        end else if (!r_edge[0]) begin
                            r_sclk <= 1'b0;
                            // The first bit is already on the line from the entry cycle.
                            if (r_edge != 6'd0) begin
                                r_sdo <= r_tx[23];
                                r_tx  <= {r_tx[22:0], 1'b0};
                            end
                        end else begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[14:0], iSPI_SDI};
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                StInitGap: begin
                    if (r_gap == GW'(CS_GAP)) begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= (r_idx == 2'd3) ? StIdle : StInit;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                StIdle: begin
                    if (r_int_sync) begin
                        r_state <= StRead;
                    end
                end
                StReadGap: begin
                    if (r_gap == GW'(CS_GAP)) begin
                        r_state <= StIdle;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign oSPI_CSN  = r_csn;
    assign oSPI_CLK  = r_sclk;
    assign oSPI_SDO  = r_sdo;
    assign oDIG      = r_dig;
    assign oDATA_INT = r_dint;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: two instances (divider 8 and 2) checked cycle by cycle against
// a transaction-level model of the SPI waveform, plus directed literal checks.
module tb_accel_spi_reader;
    localparam int D0  = 8;
    localparam int D1  = 2;
    localparam int GAP = 32;

    logic clk = 1'b0;
    logic rstn;
    logic int0, int1, sdi0, sdi1;
    logic csn0, sclk0, sdo0, dint0;
    logic csn1, sclk1, sdo1, dint1;
    logic [9:0] dig0, dig1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sx0 [2];
    logic [7:0] sx1 [2];

    // Model state, one slot per instance.
    int          win [2];
    int          off [2];
    int          nbits [2];
    int          is_read [2];
    int          ntx [2];
    int          gap [2];
    int          last_gap [2];
    int          lowcnt [2];
    int          rises [2];
    int          falls [2];
    int          tfall1 [2];
    int          sclk_per [2];
    int          nreads [2];
    int          dfalls [2];
    logic        dprev [2];
    logic        sprev [2];
    logic [9:0]  exp_dig [2];
    logic [23:0] word [2];
    logic [23:0] cap [2];
    int          lens [2][32];
    logic [23:0] caps [2][32];
    int          gaps_h [2][32];

    always #5 clk = ~clk;

    accel_spi_reader #(.CLK_DIV(D0), .CS_GAP(GAP)) u_dut0 (
        .iCLK     (clk),
        .iRSTN    (rstn),
        .iG_INT1  (int0),
        .iSPI_SDI (sdi0),
        .oSPI_CSN (csn0),
        .oSPI_CLK (sclk0),
        .oSPI_SDO (sdo0),
        .oDIG     (dig0),
        .oDATA_INT(dint0)
    );

    accel_spi_reader #(.CLK_DIV(D1), .CS_GAP(GAP)) u_dut1 (
        .iCLK     (clk),
        .iRSTN    (rstn),
        .iG_INT1  (int1),
        .iSPI_SDI (sdi1),
        .oSPI_CSN (csn1),
        .oSPI_CLK (sclk1),
        .oSPI_SDO (sdo1),
        .oDIG     (dig1),
        .oDATA_INT(dint1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [23:0] init_word(input int i);
        case (i)
            0:       return 24'h310000;
            1:       return 24'h2C0A00;
            2:       return 24'h2E8000;
            default: return 24'h2D0800;
        endcase
    endfunction

    // Sensor: bit k of {pad, DATAX0, DATAX1} goes out after the k-th SCLK fall.
    function automatic logic resp_bit(input int u, input int f);
        logic [23:0] r;
        r = {8'h00, sx0[u], sx1[u]};
        if (f >= 1 && f <= 24) return r[24-f];
        return 1'b0;
    endfunction

    int f0, f1;
    always @(negedge csn0) begin f0 = 0; sdi0 = 1'b0; end
    always @(negedge sclk0) if (!csn0) begin f0++; sdi0 = resp_bit(0, f0); end
    always @(negedge csn1) begin f1 = 0; sdi1 = 1'b0; end
    always @(negedge sclk1) if (!csn1) begin f1++; sdi1 = resp_bit(1, f1); end

    logic       o_csn, o_sclk, o_sdo, o_dint;
    logic [9:0] o_dig;
    logic [13:0] m_act, m_exp;
    int m_d, m_len, m_k, m_q;

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_d = (u == 0) ? D0 : D1;
            if (u == 0) {o_csn, o_sclk, o_sdo, o_dint, o_dig} = {csn0, sclk0, sdo0, dint0, dig0};
            else        {o_csn, o_sclk, o_sdo, o_dint, o_dig} = {csn1, sclk1, sdo1, dint1, dig1};
            m_act = {o_csn, o_sclk, o_sdo, o_dint, o_dig};
            if (!rstn) begin
                check($sformatf("reset_u%0d", u), m_act, {4'b1100, 10'h000});
                win[u] = 0; ntx[u] = 0; gap[u] = 0; exp_dig[u] = 10'h0; nreads[u] = 0;
                dfalls[u] = 0; dprev[u] = 1'b0; sprev[u] = 1'b1; last_gap[u] = 0;
                for (int j = 0; j < 32; j++) begin
                    lens[u][j] = 0; caps[u][j] = 24'h0; gaps_h[u][j] = 0;
                end
            end else begin
                if (win[u] == 0 && !o_csn) begin
                    win[u] = 1; off[u] = 0;
                    is_read[u] = (ntx[u] >= 4) ? 1 : 0;
                    nbits[u] = (is_read[u] != 0) ? 24 : 16;
                    word[u] = (is_read[u] != 0) ? 24'hF20000 : init_word(ntx[u]);
                    last_gap[u] = gap[u] + 1;
                    if (ntx[u] < 32) gaps_h[u][ntx[u]] = gap[u] + 1;
                    lowcnt[u] = 0; rises[u] = 0; falls[u] = 0; cap[u] = 24'h0;
                    ntx[u]++;
                end
                if (win[u] != 0) begin
                    m_len = m_d * (2 * nbits[u] + 1);
                    if (off[u] < m_len) begin
                        m_q = off[u] / m_d;
                        m_k = (m_q == 0) ? 0 : (m_q - 1) / 2;
                        m_exp = {1'b0, (m_q % 2 == 1) ? 1'b0 : 1'b1, word[u][23-m_k],
                                 (is_read[u] != 0), exp_dig[u]};
                        if (!o_csn) lowcnt[u]++;
                    end else begin
                        if (is_read[u] != 0) begin
                            exp_dig[u] = {sx1[u][1:0], sx0[u]};
                            nreads[u]++;
                        end
                        m_exp = {4'b1100, exp_dig[u]};
                        win[u] = 0; gap[u] = 0;
                        if (ntx[u] - 1 < 32) begin
                            lens[u][ntx[u]-1] = lowcnt[u];
                            caps[u][ntx[u]-1] = cap[u];
                        end
                    end
                    check($sformatf("cycle_u%0d", u), m_act, m_exp);
                    if (sprev[u] && !o_sclk && !o_csn) begin
                        falls[u]++;
                        if (falls[u] == 1) tfall1[u] = off[u];
                        else if (falls[u] == 2) sclk_per[u] = off[u] - tfall1[u];
                    end
                    if (!sprev[u] && o_sclk && !o_csn) begin
                        cap[u] = {cap[u][22:0], o_sdo};
                        rises[u]++;
                    end
                    off[u]++;
                end else begin
                    check($sformatf("idle_u%0d", u), m_act, {4'b1100, exp_dig[u]});
                    gap[u]++;
                end
                if (dprev[u] && !o_dint) dfalls[u]++;
                dprev[u] = o_dint;
                sprev[u] = o_sclk;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ntx(input int u, input int target, input int limit, input string name);
        for (int i = 0; i < limit && ntx[u] < target; i++) step();
        check(name, 32'(ntx[u] >= target), 32'd1);
    endtask

    task automatic wait_reads(input int u, input int target, input int limit, input string name);
        for (int i = 0; i < limit && nreads[u] < target; i++) step();
        check(name, 32'(nreads[u] >= target), 32'd1);
    endtask

    task automatic wait_idle(input int u, input int limit, input string name);
        for (int i = 0; i < limit && win[u] != 0; i++) step();
        check(name, 32'(win[u]), 32'd0);
    endtask

    task automatic pulse0();
        int0 = 1'b1;
        repeat (3) step();
        int0 = 1'b0;
    endtask

    logic [23:0] exp_init [4];

    initial begin
        exp_init[0] = 24'h003100; exp_init[1] = 24'h002C0A;
        exp_init[2] = 24'h002E80; exp_init[3] = 24'h002D08;
        rstn = 1'b1; int0 = 1'b0; int1 = 1'b0; sdi0 = 1'b0; sdi1 = 1'b0;
        sx0[0] = 8'hA5; sx1[0] = 8'h01; sx0[1] = 8'h34; sx1[1] = 8'hFE;
        #1 rstn = 1'b0;
        #2 check("reset_outputs", {csn0, sclk0, sdo0, dint0, dig0}, 14'h3000);
        int0 = 1'b1;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b1;

        // Init with the interrupt held high: four writes, then the first read.
        wait_ntx(0, 5, 3000, "init_then_read_start");
        int0 = 1'b0;
        wait_reads(0, 1, 1000, "read1_done");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_word%0d", i), caps[0][i], exp_init[i]);
            check($sformatf("init_len%0d", i), lens[0][i], 264);
        end
        for (int i = 1; i < 4; i++) check_range($sformatf("init_gap%0d", i), gaps_h[0][i], 32, 1000);
        check_range("init_to_read_gap", gaps_h[0][4], GAP + 2, GAP + 4);
        check("read1_cmd", caps[0][4], 24'hF20000);
        check("read1_len", lens[0][4], 392);
        check("read1_dig", dig0, 10'h1A5);
        repeat (300) step();
        check("no_retrigger", ntx[0], 5);

        // Single pulsed reads.
        sx0[0] = 8'h34; sx1[0] = 8'hFE;
        pulse0();
        wait_reads(0, 2, 1000, "read2_done");
        check("read2_dig", dig0, 10'h234);
        check("read2_dint", dint0, 1'b0);
        check("read2_len", lens[0][5], 392);
        repeat (300) step();
        check("pulse_one_read", ntx[0], 6);
        sx0[0] = 8'h00; sx1[0] = 8'h02;
        pulse0();
        wait_reads(0, 3, 1000, "read3_done");
        check("negfs_dig", dig0, 10'h200);

        // Back-to-back reads with the interrupt held.
        repeat (100) step();
        sx0[0] = 8'h7F; sx1[0] = 8'h01;
        int0 = 1'b1;
        wait_ntx(0, 8, 1000, "b2b_first");
        for (int i = 0; i < 3; i++) begin
            wait_ntx(0, 9 + i, 1000, $sformatf("b2b_start%0d", i));
            check_range($sformatf("b2b_gap%0d", i), last_gap[0], GAP + 2, GAP + 4);
        end
        int0 = 1'b0;
        repeat (800) step();
        check("b2b_stop", ntx[0], 11);
        check("b2b_dint_falls", dfalls[0], nreads[0]);
        check("b2b_dig", dig0, 10'h17F);

        // Minimum divider on the second instance.
        int1 = 1'b1;
        repeat (3) step();
        int1 = 1'b0;
        wait_reads(1, 1, 1000, "div2_read_done");
        check("div2_init_len", lens[1][0], 66);
        check("div2_len", lens[1][4], 98);
        check("div2_sclk_per", sclk_per[1], 4);
        check("div8_sclk_per", sclk_per[0], 16);
        check("div2_cmd", caps[1][4], 24'hF20000);
        check("div2_dig", dig1, 10'h234);

        // Reset in the middle of a read, after ten sampled bits.
        int0 = 1'b1;
        for (int i = 0; i < 3000 && !(win[0] != 0 && is_read[0] != 0 && rises[0] >= 10); i++)
            step();
        check("midread_reached", 32'(win[0] != 0 && is_read[0] != 0 && rises[0] >= 10), 32'd1);
        #2 rstn = 1'b0;
        #1 check("midread_reset_u0", {csn0, sclk0, sdo0, dint0, dig0}, 14'h3000);
        check("midread_reset_u1", {csn1, dint1, dig1}, 12'h800);
        int0 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rstn = 1'b1;
        wait_ntx(0, 1, 200, "replay_start");
        wait_idle(0, 1000, "replay_w0_done");
        check("replay_word0", caps[0][0], 24'h003100);
        check("replay_len0", lens[0][0], 264);
        wait_ntx(0, 4, 2000, "replay_w3_start");
        wait_idle(0, 1000, "replay_w3_done");
        check("replay_word3", caps[0][3], 24'h002D08);
        check("replay_dig", dig0, 10'h000);
        repeat (100) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
